// File: rtl/r5fp_mul_seq_pkg.sv
// Shared types for the sequential R5FP multiplier: FSM states, operand classes
// and status-flag bit positions.
package r5fp_mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        NORM,
        ZERO,
        INF,
        QNAN,
        SNAN
    } op_class_t;

    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_INVALID = 3;
    localparam int STATUS_W   = 6;

    function automatic logic is_nan(input op_class_t c);
        return (c == QNAN) || (c == SNAN);
    endfunction

endpackage

// File: rtl/r5fp_mul_seq_if.sv
// Operand/result handshake bundle between an initiator and r5fp_mul_seq.
interface r5fp_mul_seq_if #(
    parameter int EXP_W = 6,
    parameter int SIG_W = 6
);
    logic                      in_valid;
    logic                      in_ready;
    logic [EXP_W+SIG_W:0]      a;
    logic [EXP_W+SIG_W:0]      b;
    logic                      out_valid;
    logic                      out_ready;
    logic                      zSign;
    logic signed [EXP_W+1:0]   zExp;
    logic [2*SIG_W+2:0]        zSig;
    logic [5:0]                zStatus;
    logic                      busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, zSign, zExp, zSig, zStatus, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, zSign, zExp, zSig, zStatus, busy
    );
endinterface

// File: rtl/r5fp_mul_seq_classify.sv
// Combinational classifier for one operand in the R5FP extended-exponent format.
module r5fp_mul_seq_classify
    import r5fp_mul_seq_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int SIG_W = 6
) (
    input  logic [EXP_W-1:0] i_exp,
    input  logic [SIG_W-1:0] i_frac,
    output op_class_t        o_cls
);

    always_comb begin
        o_cls = NORM;
        if (&i_exp) begin
            if (i_frac == '0)
                o_cls = INF;
            else if (i_frac[SIG_W-1])
                o_cls = QNAN;
            else
                o_cls = SNAN;
        end else if ((i_exp == '0) && (i_frac == '0)) begin
            o_cls = ZERO;
        end
    end

endmodule

// File: rtl/r5fp_mul_seq.sv
// Iterative shift-add R5FP multiplier producing an unrounded result for postproc.
// Build option R5FP_MUL_SEQ_RADIX4_EN retires two multiplier bits per cycle.
module r5fp_mul_seq
    import r5fp_mul_seq_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int SIG_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    r5fp_mul_seq_if.slave   bus
);

    localparam int N      = SIG_W + 1;
`ifdef R5FP_MUL_SEQ_RADIX4_EN
    localparam int R      = 2;
`else
    localparam int R      = 1;
`endif
    localparam int ITER    = (N + R - 1) / R;
    localparam int RS      = R * ITER;
    localparam int L       = RS + N;
    localparam int CW      = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int ITER_M1 = ITER - 1;
    localparam int OP_W    = EXP_W + SIG_W + 1;
    localparam int BIAS_I  = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EXP_W+1:0] BIAS = BIAS_I[EXP_W+1:0];

    logic               w_a_sign, w_b_sign;
    logic [EXP_W-1:0]   w_a_exp, w_b_exp;
    logic [SIG_W-1:0]   w_a_frac, w_b_frac;
    op_class_t          w_a_cls, w_b_cls;

    assign w_a_sign = bus.a[OP_W-1];
    assign w_b_sign = bus.b[OP_W-1];
    assign w_a_exp  = bus.a[OP_W-2 -: EXP_W];
    assign w_b_exp  = bus.b[OP_W-2 -: EXP_W];
    assign w_a_frac = bus.a[SIG_W-1:0];
    assign w_b_frac = bus.b[SIG_W-1:0];

    r5fp_mul_seq_classify #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_cls_a (
        .i_exp  (w_a_exp),
        .i_frac (w_a_frac),
        .o_cls  (w_a_cls)
    );

    r5fp_mul_seq_classify #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_cls_b (
        .i_exp  (w_b_exp),
        .i_frac (w_b_frac),
        .o_cls  (w_b_cls)
    );

    // Special-operand resolution, NaN first, then Inf*0, Inf, Zero
    logic                w_special;
    logic [STATUS_W-1:0] w_status;

    always_comb begin
        w_special = 1'b1;
        w_status  = '0;
        if (is_nan(w_a_cls) || is_nan(w_b_cls)) begin
            w_status[ST_NAN]     = 1'b1;
            w_status[ST_INVALID] = (w_a_cls == SNAN) || (w_b_cls == SNAN);
        end else if (((w_a_cls == INF) && (w_b_cls == ZERO)) ||
                     ((w_a_cls == ZERO) && (w_b_cls == INF))) begin
            w_status[ST_NAN]     = 1'b1;
            w_status[ST_INVALID] = 1'b1;
        end else if ((w_a_cls == INF) || (w_b_cls == INF)) begin
            w_status[ST_INF] = 1'b1;
        end else if ((w_a_cls == ZERO) || (w_b_cls == ZERO)) begin
            w_status[ST_ZERO] = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    logic signed [EXP_W+1:0] w_exp_sum;
    assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;
    logic                    r_zsign;
    logic signed [EXP_W+1:0] r_zexp;
    logic [2*SIG_W+2:0]      r_zsig;
    logic [STATUS_W-1:0]     r_zstatus;
    logic [N-1:0]            r_a;
    logic [L-1:0]            r_acc;
    logic [RS-1:0]           r_mplr;
    logic [CW-1:0]           r_cnt;
`ifdef R5FP_MUL_SEQ_RADIX4_EN
    logic [N+1:0]            r_a3;
`endif

    // The high N bits of acc receive the addend; acc then shifts right by R
    logic [N+R-1:0] w_addend;
    logic [N+R-1:0] w_step_sum;
    logic [L-1:0]   w_acc_next;

    always_comb begin
        w_addend = '0;
`ifdef R5FP_MUL_SEQ_RADIX4_EN
        case (r_mplr[1:0])
            2'd1:    w_addend = {2'b00, r_a};
            2'd2:    w_addend = {1'b0, r_a, 1'b0};
            2'd3:    w_addend = r_a3;
            default: w_addend = '0;
        endcase
`else
        if (r_mplr[0])
            w_addend = {1'b0, r_a};
`endif
        w_step_sum = {{R{1'b0}}, r_acc[L-1:RS]} + w_addend;
        w_acc_next = {w_step_sum, r_acc[RS-1:R]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_zsign     <= 1'b0;
            r_zexp      <= '0;
            r_zsig      <= '0;
            r_zstatus   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_zsign    <= w_a_sign ^ w_b_sign;
                        r_a        <= {1'b1, w_a_frac};
                        r_acc      <= '0;
                        r_mplr     <= '0;
                        r_mplr[N-1:0] <= {1'b1, w_b_frac};
                        r_cnt      <= ITER_M1[CW-1:0];
`ifdef R5FP_MUL_SEQ_RADIX4_EN
                        r_a3       <= {2'b00, 1'b1, w_a_frac} + {1'b0, 1'b1, w_a_frac, 1'b0};
`endif
                        if (w_special) begin
                            r_zexp      <= '0;
                            r_zsig      <= '0;
                            r_zstatus   <= w_status;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_zexp    <= w_exp_sum;
                            r_zstatus <= '0;
                            r_state   <= MUL;
                        end
                    end
                end
                MUL: begin
                    r_acc  <= w_acc_next;
                    r_mplr <= r_mplr >> R;
                    if (r_cnt == '0) begin
                        r_zsig      <= {w_acc_next[2*N-1:0], 1'b0};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.zSign     = r_zsign;
    assign bus.zExp      = r_zexp;
    assign bus.zSig      = r_zsig;
    assign bus.zStatus   = r_zstatus;

endmodule
